sd2vc: RTL

- Converts a srdy/drdy (sd) producer stream into a valid/credit (vc) output stream for a credit-managed downstream buffer.
- It is the transmit end paired with vc2sd: `p_vld`/`p_data` drive vc2sd `c_vld`/`c_data`, and vc2sd `c_cr` returns here as `p_cr`.
- Holds a credit counter sized to the downstream buffer depth. It issues a word only when a credit is available, so the receiver can never overflow.

---
 rtl/sd2vc_pkg.sv | 13 +
 rtl/vc_credit_cnt.sv | 49 ++++
 rtl/sd2vc.sv | 52 +++++
 3 files changed

// File: rtl/sd2vc_pkg.sv
// Shared defaults and sizing helpers for the sd2vc credit-managed transmitter
// and its reusable credit counter.
package sd2vc_pkg;

  localparam int SD2VC_DEF_WIDTH   = 8;
  localparam int SD2VC_DEF_CREDITS = 16;

  // Bits needed to hold every value from 0 up to and including n.
  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vc_credit_cnt.sv
// Credit counter for a valid/credit transmitter: decrements on issue, increments
// on credit return, saturates at the initial count and flags overflow stickily.
module vc_credit_cnt
  import sd2vc_pkg::*;
#(
  parameter int credits = SD2VC_DEF_CREDITS,
  parameter int csz     = credit_width(credits)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           dec,
  input  logic           inc,
  output logic [csz-1:0] cnt,
  output logic           nonzero,
  output logic           err
);

  localparam logic [csz:0]   MAX_EXT = (csz + 1)'(credits);
  localparam logic [csz-1:0] MAX_CNT = csz'(credits);

  logic [csz:0]   sum;
  logic           ovf;
  logic [csz-1:0] cnt_nxt;

  // One extra bit so a return at full count is visible as a value above credits
  // rather than wrapping back to zero.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branching so that
    // no path leaves it unassigned, which would infer a latch.
    sum     = {1'b0, cnt} - {{csz{1'b0}}, dec} + {{csz{1'b0}}, inc};
    ovf     = (sum > MAX_EXT);
    cnt_nxt = ovf ? MAX_CNT : sum[csz-1:0];
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= MAX_CNT;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (ovf) err <= 1'b1;
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/sd2vc.sv
// srdy/drdy to valid/credit converter: accepts a word only while downstream
// credit remains and presents it one cycle later as a single-cycle p_vld pulse.
module sd2vc
  import sd2vc_pkg::*;
#(
  parameter int width   = SD2VC_DEF_WIDTH,
  parameter int credits = SD2VC_DEF_CREDITS,
  parameter int csz     = credit_width(credits)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_vld,
  output logic [width-1:0] p_data,
  input  logic             p_cr,
  output logic [csz-1:0]   credit_cnt,
  output logic             cr_err
);

  logic cnt_nonzero;
  logic xfer;

  // Ready depends only on reset and the registered count, never on c_srdy or p_cr.
  assign c_drdy = !reset && cnt_nonzero;
  assign xfer   = c_srdy && c_drdy;

  vc_credit_cnt #(
    .credits (credits),
    .csz     (csz)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .dec     (xfer),
    .inc     (p_cr),
    .cnt     (credit_cnt),
    .nonzero (cnt_nonzero),
    .err     (cr_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld  <= 1'b0;
      p_data <= '0;
    end else begin
      p_vld <= xfer;
      if (xfer) p_data <= c_data;
    end
  end

endmodule
